// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl
//   HDLC receive framer. Finds flags and aborts on the serial line, removes
//   stuffed zeros from the payload, assembles bytes LSB first and reports
//   frame boundaries, size, overflow and framing errors.
//
// Ports
//   Clk            in   single clock, rising edge
//   Rst            in   asynchronous active-high reset
//   RxEN           in   receiver enable; low forces HUNT and mutes pulses
//   Rx             in   serial line, one bit per clock, LSB of each byte first
//   Rx_FlagDetect  out  pulse per flag, two edges after the flag's last bit
//   Rx_AbortSignal out  pulse when an abort ends an open frame
//   Rx_ValidFrame  out  high while payload of a frame is being received
//   Rx_Data        out  assembled payload byte, valid with Rx_WrBuff
//   Rx_WrBuff      out  write strobe per payload byte
//   Rx_EoF         out  pulse at end of frame (closing flag or abort)
//   Rx_FrameSize   out  bytes written in the last frame, updated with Rx_EoF
//   Rx_Overflow    out  frame exceeded MAX_BYTES; cleared by next opening flag
//   Rx_FrameError  out  frame ended off a byte boundary or by abort
module rx_frame_ctrl #(
    parameter int unsigned MAX_BYTES = 128
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RxEN,
    input  logic       Rx,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortSignal,
    output logic       Rx_ValidFrame,
    output logic [7:0] Rx_Data,
    output logic       Rx_WrBuff,
    output logic       Rx_EoF,
    output logic [7:0] Rx_FrameSize,
    output logic       Rx_Overflow,
    output logic       Rx_FrameError
);

    localparam logic [7:0] MAX_B = 8'(MAX_BYTES);

    typedef enum logic [1:0] {
        HUNT,
        OPEN,
        RECV
    } state_t;

    state_t     state;
    logic [7:0] line_sr;    // last 8 line bits, oldest in bit 0
    logic [3:0] ones_line;  // consecutive ones on the raw line, saturating
    logic       flag_d;
    logic [2:0] skip_cnt;
    logic [2:0] ones_run;
    logic [2:0] bit_cnt;
    logic [7:0] byte_sr;
    logic [7:0] byte_cnt;

    logic       flag_match;
    logic       abort_match;
    logic       idle;
    logic       pay_bit;
    logic       stuffed;
    logic [7:0] byte_next;

    // Line patterns read oldest-first from bit 0: flag 0,1,1,1,1,1,1,0 and
    // abort 0 followed by seven 1s.
    assign flag_match  = (line_sr == 8'h7E);
    assign abort_match = (line_sr == 8'hFE);
    assign idle        = (ones_line == 4'd15);

    // Payload is consumed from the oldest shift-register bit, 8 cycles behind
    // the line. A flag or abort containing that bit is therefore always
    // already matched, so flag/abort bits can be kept out of the assembler.
    assign pay_bit   = line_sr[0];
    assign stuffed   = (ones_run == 3'd5) && !pay_bit;
    assign byte_next = {pay_bit, byte_sr[7:1]};

    assign Rx_ValidFrame = (state == RECV);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state          <= HUNT;
            line_sr        <= '1;
            ones_line      <= '0;
            flag_d         <= 1'b0;
            skip_cnt       <= '0;
            ones_run       <= '0;
            bit_cnt        <= '0;
            byte_sr        <= '0;
            byte_cnt       <= '0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortSignal <= 1'b0;
            Rx_Data        <= '0;
            Rx_WrBuff      <= 1'b0;
            Rx_EoF         <= 1'b0;
            Rx_FrameSize   <= '0;
            Rx_Overflow    <= 1'b0;
            Rx_FrameError  <= 1'b0;
        end else begin
            line_sr        <= {Rx, line_sr[7:1]};
            ones_line      <= Rx ? ((ones_line == 4'd15) ? 4'd15 : ones_line + 4'd1) : '0;
            flag_d         <= RxEN & flag_match;
            Rx_FlagDetect  <= RxEN & flag_d;
            Rx_AbortSignal <= 1'b0;
            Rx_WrBuff      <= 1'b0;
            Rx_EoF         <= 1'b0;

            if (!RxEN) begin
                state    <= HUNT;
                skip_cnt <= '0;
                ones_run <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (flag_match) begin
                if (state == RECV) begin
                    Rx_EoF        <= 1'b1;
                    Rx_FrameSize  <= byte_cnt;
                    Rx_FrameError <= (bit_cnt != 3'd0);
                end else begin
                    Rx_Overflow   <= 1'b0;
                    Rx_FrameError <= 1'b0;
                end
                state    <= OPEN;
                // remaining seven flag bits still have to drain past the tap
                skip_cnt <= 3'd7;
                ones_run <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (abort_match || idle) begin
                if (abort_match && (state == RECV)) begin
                    Rx_AbortSignal <= 1'b1;
                    Rx_EoF         <= 1'b1;
                    Rx_FrameSize   <= byte_cnt;
                    Rx_FrameError  <= 1'b1;
                end
                state    <= HUNT;
                skip_cnt <= '0;
                ones_run <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (state != HUNT) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else if (stuffed) begin
                    ones_run <= '0;
                end else begin
                    state    <= RECV;
                    ones_run <= pay_bit ? ((ones_run == 3'd7) ? 3'd7 : ones_run + 3'd1) : '0;
                    byte_sr  <= byte_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (byte_cnt < MAX_B) begin
                            Rx_WrBuff <= 1'b1;
                            Rx_Data   <= byte_next;
                            byte_cnt  <= byte_cnt + 8'd1;
                        end else begin
                            Rx_Overflow <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl
//   Builds HDLC bit streams from frame descriptions (bytes, trailing partial
//   bits, flag or abort ending), predicts the writes, end-of-frame records,
//   abort pulses and flag pulses from those descriptions, and compares them
//   with what the receiver reports.
module tb_rx_frame_ctrl;

    localparam int unsigned MAX_BYTES = 128;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       RxEN;
    logic       Rx;
    logic       Rx_FlagDetect;
    logic       Rx_AbortSignal;
    logic       Rx_ValidFrame;
    logic [7:0] Rx_Data;
    logic       Rx_WrBuff;
    logic       Rx_EoF;
    logic [7:0] Rx_FrameSize;
    logic       Rx_Overflow;
    logic       Rx_FrameError;

    rx_frame_ctrl #(.MAX_BYTES(MAX_BYTES)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .RxEN           (RxEN),
        .Rx             (Rx),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_AbortSignal (Rx_AbortSignal),
        .Rx_ValidFrame  (Rx_ValidFrame),
        .Rx_Data        (Rx_Data),
        .Rx_WrBuff      (Rx_WrBuff),
        .Rx_EoF         (Rx_EoF),
        .Rx_FrameSize   (Rx_FrameSize),
        .Rx_Overflow    (Rx_Overflow),
        .Rx_FrameError  (Rx_FrameError)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    bit         bits[$];
    int         stuff_ones;
    logic [7:0] frame_q[$];

    int         exp_flag[$];
    int         exp_abort[$];
    logic [7:0] exp_data[$];
    logic [9:0] exp_eof[$];   // {size, error, overflow}
    int         got_flag[$];
    int         got_abort[$];
    logic [7:0] got_data[$];
    logic [9:0] got_eof[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_raw(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) bits.push_back(v[i]);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) bits.push_back(1'b1);
    endtask

    task automatic push_pay_bit(input logic b);
        bits.push_back(b);
        if (b) begin
            stuff_ones++;
            if (stuff_ones == 5) begin
                bits.push_back(1'b0);
                stuff_ones = 0;
            end
        end else begin
            stuff_ones = 0;
        end
    endtask

    task automatic push_pay_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) push_pay_bit(v[i]);
    endtask

    // Frame from frame_q plus 'part' extra payload bits, closed by a flag or an abort.
    task automatic add_frame(input int part, input bit abort_end);
        int         n;
        int         kept;
        logic [7:0] pb;
        logic       ovf;
        n    = frame_q.size();
        kept = (n > int'(MAX_BYTES)) ? int'(MAX_BYTES) : n;
        ovf  = (n > int'(MAX_BYTES));
        push_raw(8'h7E, 8);
        stuff_ones = 0;
        foreach (frame_q[i]) push_pay_byte(frame_q[i]);
        pb = 8'($urandom);
        for (int b = 0; b < part; b++) push_pay_bit(pb[b]);
        for (int i = 0; i < kept; i++) exp_data.push_back(frame_q[i]);
        if (abort_end) begin
            push_raw(8'hFE, 8);
            if (n * 8 + part > 0) begin
                exp_abort.push_back(bits.size());
                exp_eof.push_back({8'(kept), 1'b1, ovf});
            end
            push_idle($urandom_range(0, 6));
        end else begin
            push_raw(8'h7E, 8);
            if (n * 8 + part > 0) exp_eof.push_back({8'(kept), part != 0, ovf});
        end
    endtask

    // Drives bits[from..to-1]; edge i samples bits[i]; outputs read at the following negedge.
    task automatic run_stream(input int from, input int to);
        for (int i = from; i < to; i++) begin
            Rx = bits[i];
            @(posedge Clk);
            @(negedge Clk);
            if (Rx_FlagDetect)  got_flag.push_back(i);
            if (Rx_AbortSignal) got_abort.push_back(i);
            if (Rx_WrBuff)      got_data.push_back(Rx_Data);
            if (Rx_EoF)         got_eof.push_back({Rx_FrameSize, Rx_FrameError, Rx_Overflow});
        end
    endtask

    task automatic compare_phase(input string tag);
        logic [7:0] w;
        int         n;
        for (int k = 7; k + 2 < bits.size(); k++) begin
            for (int j = 0; j < 8; j++) w[j] = bits[k - 7 + j];
            if (w == 8'h7E) exp_flag.push_back(k + 2);
        end
        check_eq({tag, "_flag_count"}, got_flag.size(), exp_flag.size());
        n = (got_flag.size() < exp_flag.size()) ? got_flag.size() : exp_flag.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_flag%0d_edge", tag, i), got_flag[i], exp_flag[i]);
        check_eq({tag, "_write_count"}, got_data.size(), exp_data.size());
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_write%0d_data", tag, i), got_data[i], exp_data[i]);
        check_eq({tag, "_eof_count"}, got_eof.size(), exp_eof.size());
        n = (got_eof.size() < exp_eof.size()) ? got_eof.size() : exp_eof.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_eof%0d_size_err_ovf", tag, i), got_eof[i], exp_eof[i]);
        check_eq({tag, "_abort_count"}, got_abort.size(), exp_abort.size());
        n = (got_abort.size() < exp_abort.size()) ? got_abort.size() : exp_abort.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_abort%0d_edge", tag, i), got_abort[i], exp_abort[i]);
        bits.delete();
        exp_flag.delete();
        exp_abort.delete();
        exp_data.delete();
        exp_eof.delete();
        got_flag.delete();
        got_abort.delete();
        got_data.delete();
        got_eof.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_flag"},  Rx_FlagDetect,  0);
        check_eq({tag, "_abort"}, Rx_AbortSignal, 0);
        check_eq({tag, "_valid"}, Rx_ValidFrame,  0);
        check_eq({tag, "_data"},  Rx_Data,        0);
        check_eq({tag, "_wr"},    Rx_WrBuff,      0);
        check_eq({tag, "_eof"},   Rx_EoF,         0);
        check_eq({tag, "_size"},  Rx_FrameSize,   0);
        check_eq({tag, "_ovf"},   Rx_Overflow,    0);
        check_eq({tag, "_ferr"},  Rx_FrameError,  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int split;
        int split2;

        Rst  = 1'b1;
        RxEN = 1'b1;
        Rx   = 1'b1;
        @(negedge Clk);
        check_all_zero("reset");
        @(negedge Clk);
        Rst = 1'b0;

        // Directed frames followed by random ones, all in one continuous stream.
        push_idle(12);
        frame_q.delete(); frame_q.push_back(8'h5A); frame_q.push_back(8'hC3);
        add_frame(0, 0);
        frame_q.delete(); frame_q.push_back(8'hFF);
        add_frame(0, 0);
        frame_q.delete(); frame_q.push_back(8'h12);
        add_frame(0, 1);
        push_idle(4);
        frame_q.delete();
        for (int i = 0; i < 130; i++) frame_q.push_back(8'h00);
        add_frame(0, 0);
        frame_q.delete(); frame_q.push_back(8'h77);
        add_frame(0, 0);
        frame_q.delete(); frame_q.push_back(8'h9C);
        add_frame(3, 0);
        for (int f = 0; f < 25; f++) begin
            frame_q.delete();
            for (int i = $urandom_range(0, 5); i > 0; i--)
                frame_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            add_frame(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7)),
                      $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) push_idle($urandom_range(8, 12));
        end
        push_idle(20);
        run_stream(0, bits.size());
        compare_phase("stream");

        // Enable dropped mid-frame: written bytes stay, no end-of-frame.
        push_idle(4);
        push_raw(8'h7E, 8);
        stuff_ones = 0;
        push_pay_byte(8'h11);
        push_pay_byte(8'h22);
        push_pay_byte(8'h44);
        exp_data.push_back(8'h11);
        exp_data.push_back(8'h22);
        split = bits.size();
        run_stream(0, split);
        check_eq("rxen_valid_before", Rx_ValidFrame, 1);
        RxEN = 1'b0;
        push_idle(4);
        split2 = bits.size();
        run_stream(split, split2);
        check_eq("rxen_valid_off", Rx_ValidFrame, 0);
        RxEN = 1'b1;
        push_idle(10);
        frame_q.delete(); frame_q.push_back(8'h33);
        add_frame(0, 0);
        push_idle(12);
        run_stream(split2, bits.size());
        compare_phase("rxen");

        // Asynchronous reset between clock edges in the middle of a frame.
        push_idle(4);
        push_raw(8'h7E, 8);
        stuff_ones = 0;
        push_pay_byte(8'h3C);
        push_pay_byte(8'h81);
        push_pay_byte(8'h42);
        exp_data.push_back(8'h3C);
        exp_data.push_back(8'h81);
        run_stream(0, bits.size());
        check_eq("pre_reset_valid", Rx_ValidFrame, 1);
        compare_phase("pre_reset");
        #2;
        Rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        push_idle(10);
        frame_q.delete(); frame_q.push_back(8'h5A);
        add_frame(0, 0);
        push_idle(12);
        run_stream(0, bits.size());
        compare_phase("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
